// File: rtl/regfile_mp.sv
// Multi-port integer register file: async reads with write bypass, two write ports,
// a pending-write scoreboard, and a sequential init engine that zeroes the array.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int NRP      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hold,
  input  logic                  init_req,
  output logic                  init_done,
  input  logic [NRP*AW-1:0]     rd_addr,
  output logic [NRP*XLEN-1:0]   rd_data,
  output logic [NRP-1:0]        rd_busy,
  input  logic                  wen0,
  input  logic [AW-1:0]         waddr0,
  input  logic [XLEN-1:0]       wdata0,
  input  logic                  wen1,
  input  logic [AW-1:0]         waddr1,
  input  logic [XLEN-1:0]       wdata1,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_addr
);

  localparam int NREGS = 1 << AW;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [XLEN-1:0]   mem_q [NREGS];

  logic runActive, initAccept, writeOk;
  logic commit0, commit1, issueSet;

  assign runActive  = (state_q == ST_RUN);
  assign initAccept = runActive && init_req && !hold;
  assign writeOk    = runActive && !hold && !init_req;
  assign init_done  = runActive;

  // Port 1 wins a same-address collision, so port 0 is suppressed outright.
  assign commit1  = writeOk && wen1 && !((ZERO_REG != 0) && (waddr1 == '0));
  assign commit0  = writeOk && wen0 && !((ZERO_REG != 0) && (waddr0 == '0))
                    && !(commit1 && (waddr1 == waddr0));
  assign issueSet = writeOk && iss_en && !((ZERO_REG != 0) && (iss_addr == '0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(NREGS - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (initAccept) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // Clears are applied before the issue set so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    if (initAccept) begin
      busy_d = '0;
    end else begin
      if (commit0)  busy_d[waddr0]   = 1'b0;
      if (commit1)  busy_d[waddr1]   = 1'b0;
      if (issueSet) busy_d[iss_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // The array has no reset; the INIT walk is what makes its contents valid.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[cnt_q] <= '0;
    end else begin
      if (commit0) mem_q[waddr0] <= wdata0;
      if (commit1) mem_q[waddr1] <= wdata1;
    end
  end

  for (genvar k = 0; k < NRP; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic            hit0, hit1;
    logic [XLEN-1:0] rdata;
    logic            rbusy;

    assign addr = rd_addr[k*AW +: AW];
    assign hit1 = commit1 && (waddr1 == addr);
    assign hit0 = commit0 && (waddr0 == addr);

    always_comb begin
      rdata = '0;
      rbusy = 1'b0;
      if (runActive && !((ZERO_REG != 0) && (addr == '0))) begin
        if (hit1)      rdata = wdata1;
        else if (hit0) rdata = wdata0;
        else           rdata = mem_q[addr];
        rbusy = busy_q[addr] && !(hit0 || hit1);
      end
    end

    assign rd_data[k*XLEN +: XLEN] = rdata;
    assign rd_busy[k]              = rbusy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: init timing, write/bypass vectors via a
// scoreboard queue, and hand-written init_req / mid-init reset sequences.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NRP  = 2;

  logic                clk = 1'b0;
  logic                rst_n, hold, init_req, init_done;
  logic [NRP*AW-1:0]   rd_addr;
  logic [NRP*XLEN-1:0] rd_data;
  logic [NRP-1:0]      rd_busy;
  logic                wen0, wen1, iss_en;
  logic [AW-1:0]       waddr0, waddr1, iss_addr;
  logic [XLEN-1:0]     wdata0, wdata1;

  int checkCount = 0;
  int failCount  = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .AW(AW), .NRP(NRP), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .init_req(init_req), .init_done(init_done),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .iss_en(iss_en), .iss_addr(iss_addr)
  );

  typedef struct {
    string           name;
    logic            hold;
    logic            wen0;
    logic [AW-1:0]   waddr0;
    logic [XLEN-1:0] wdata0;
    logic            wen1;
    logic [AW-1:0]   waddr1;
    logic [XLEN-1:0] wdata1;
    logic            issEn;
    logic [AW-1:0]   issAddr;
    logic [AW-1:0]   ra0;
    logic [AW-1:0]   ra1;
    logic [XLEN-1:0] expD0;
    logic [XLEN-1:0] expD1;
    logic [1:0]      expBusy;
  } vec_t;

  typedef struct {
    string           name;
    logic [XLEN-1:0] d0;
    logic [XLEN-1:0] d1;
    logic [1:0]      busy;
  } exp_t;

  exp_t sbQ[$];
  vec_t vecs[21];

  function automatic vec_t mk(string n, logic h,
                              logic w0, logic [AW-1:0] a0, logic [XLEN-1:0] d0,
                              logic w1, logic [AW-1:0] a1, logic [XLEN-1:0] d1,
                              logic ie, logic [AW-1:0] ia,
                              logic [AW-1:0] r0, logic [AW-1:0] r1,
                              logic [XLEN-1:0] e0, logic [XLEN-1:0] e1, logic [1:0] eb);
    vec_t v;
    v.name = n; v.hold = h;
    v.wen0 = w0; v.waddr0 = a0; v.wdata0 = d0;
    v.wen1 = w1; v.waddr1 = a1; v.wdata1 = d1;
    v.issEn = ie; v.issAddr = ia; v.ra0 = r0; v.ra1 = r1;
    v.expD0 = e0; v.expD1 = e1; v.expBusy = eb;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    hold = 1'b0; init_req = 1'b0;
    wen0 = 1'b0; waddr0 = '0; wdata0 = '0;
    wen1 = 1'b0; waddr1 = '0; wdata1 = '0;
    iss_en = 1'b0; iss_addr = '0; rd_addr = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    hold = v.hold;
    wen0 = v.wen0; waddr0 = v.waddr0; wdata0 = v.wdata0;
    wen1 = v.wen1; waddr1 = v.waddr1; wdata1 = v.wdata1;
    iss_en = v.issEn; iss_addr = v.issAddr;
    rd_addr = {v.ra1, v.ra0};
    e.name = v.name; e.d0 = v.expD0; e.d1 = v.expD1; e.busy = v.expBusy;
    sbQ.push_back(e);
  endtask

  task automatic popAndCompare();
    exp_t e;
    if (sbQ.size() == 0) begin
      checkCount++;
      failCount++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sbQ.pop_front();
      checkOutput({e.name, "_d0"}, rd_data[XLEN-1:0], e.d0);
      checkOutput({e.name, "_d1"}, rd_data[2*XLEN-1:XLEN], e.d1);
      checkOutput({e.name, "_busy"}, XLEN'(rd_busy), XLEN'(e.busy));
    end
  endtask

  task automatic waitInit(input string name, input int expCycles);
    int cycles;
    logic done;
    cycles = 0;
    done = 1'b0;
    while (cycles < 200 && !done) begin
      @(posedge clk);
      #2;
      cycles++;
      done = init_done;
    end
    checkOutput(name, XLEN'(cycles), XLEN'(expCycles));
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = mk("wr_both",    0, 1, 5'd5, 32'h1234, 1, 5'd6, 32'hABCD, 0, 5'd0,  5'd5,  5'd6,  32'h1234, 32'hABCD, 2'b00);
    vecs[1]  = mk("rd_both",    0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0,  5'd5,  5'd6,  32'h1234, 32'hABCD, 2'b00);
    vecs[2]  = mk("same_addr",  0, 1, 5'd7, 32'h11,   1, 5'd7, 32'h22,   0, 5'd0,  5'd7,  5'd7,  32'h22,   32'h22,   2'b00);
    vecs[3]  = mk("same_store", 0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0,  5'd7,  5'd7,  32'h22,   32'h22,   2'b00);
    vecs[4]  = mk("wr_x0",      0, 1, 5'd0, 32'hFF,   0, 5'd0, 32'h0,    0, 5'd0,  5'd0,  5'd0,  32'h0,    32'h0,    2'b00);
    vecs[5]  = mk("wr1_x0",     0, 0, 5'd0, 32'h0,    1, 5'd0, 32'hFF,   0, 5'd0,  5'd0,  5'd0,  32'h0,    32'h0,    2'b00);
    vecs[6]  = mk("wr_x8",      0, 0, 5'd0, 32'h0,    1, 5'd8, 32'h33,   0, 5'd0,  5'd8,  5'd5,  32'h33,   32'h1234, 2'b00);
    vecs[7]  = mk("hold_wr",    1, 1, 5'd8, 32'h55,   0, 5'd0, 32'h0,    0, 5'd0,  5'd8,  5'd8,  32'h33,   32'h33,   2'b00);
    vecs[8]  = mk("hold_rel",   0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0,  5'd8,  5'd8,  32'h33,   32'h33,   2'b00);
    vecs[9]  = mk("iss_x9",     0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    1, 5'd9,  5'd9,  5'd9,  32'h0,    32'h0,    2'b00);
    vecs[10] = mk("busy_x9",    0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0,  5'd9,  5'd9,  32'h0,    32'h0,    2'b11);
    vecs[11] = mk("iss_wr_x9",  0, 0, 5'd0, 32'h0,    1, 5'd9, 32'h99,   1, 5'd9,  5'd9,  5'd9,  32'h99,   32'h99,   2'b00);
    vecs[12] = mk("busy_keep",  0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0,  5'd9,  5'd9,  32'h99,   32'h99,   2'b11);
    vecs[13] = mk("wr0_x9",     0, 1, 5'd9, 32'hAA,   0, 5'd0, 32'h0,    0, 5'd0,  5'd9,  5'd9,  32'hAA,   32'hAA,   2'b00);
    vecs[14] = mk("clr_x9",     0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0,  5'd9,  5'd9,  32'hAA,   32'hAA,   2'b00);
    vecs[15] = mk("hold_iss",   1, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    1, 5'd10, 5'd10, 5'd10, 32'h0,    32'h0,    2'b00);
    vecs[16] = mk("hold_iss2",  0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0,  5'd10, 5'd10, 32'h0,    32'h0,    2'b00);
    vecs[17] = mk("iss_x0",     0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    1, 5'd0,  5'd0,  5'd0,  32'h0,    32'h0,    2'b00);
    vecs[18] = mk("iss_x0_2",   0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0,  5'd0,  5'd0,  32'h0,    32'h0,    2'b00);
    vecs[19] = mk("prep_x3x4",  0, 1, 5'd3, 32'h77,   0, 5'd0, 32'h0,    1, 5'd4,  5'd3,  5'd4,  32'h77,   32'h0,    2'b00);
    vecs[20] = mk("chk_x3x4",   0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0,  5'd3,  5'd4,  32'h77,   32'h0,    2'b10);

    // Reset release with hold high: INIT must still take exactly 32 cycles.
    clearInputs();
    hold  = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_init_done", XLEN'(init_done), 32'h0);
    checkOutput("reset_busy", XLEN'(rd_busy), 32'h0);
    rst_n = 1'b1;
    waitInit("init_cycles", 32);
    for (int i = 0; i < 32; i++) begin
      rd_addr = {AW'(31 - i), AW'(i)};
      #1;
      checkOutput($sformatf("init_zero_p0_x%0d", i), rd_data[XLEN-1:0], 32'h0);
      checkOutput($sformatf("init_zero_p1_x%0d", 31 - i), rd_data[2*XLEN-1:XLEN], 32'h0);
    end

    for (int i = 0; i < 21; i++) begin
      @(posedge clk);
      #1;
      applyStimulus(vecs[i]);
      @(negedge clk);
      popAndCompare();
    end

    // init_req in RUN: the concurrent write is dropped and busy is cleared.
    @(posedge clk);
    #1;
    clearInputs();
    init_req = 1'b1;
    wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h12;
    rd_addr = {5'd4, 5'd3};
    #3;
    checkOutput("initreq_done_still", XLEN'(init_done), 32'h1);
    checkOutput("initreq_no_bypass", rd_data[XLEN-1:0], 32'h77);
    @(posedge clk);
    #1;
    init_req = 1'b0;
    wen0 = 1'b0;
    wen1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'h66;
    #1;
    checkOutput("reinit_done_low", XLEN'(init_done), 32'h0);
    checkOutput("reinit_rd_zero", rd_data[XLEN-1:0], 32'h0);
    checkOutput("reinit_busy_zero", XLEN'(rd_busy), 32'h0);
    wen1 = 1'b0;
    waitInit("reinit_cycles", 32);
    #1;
    checkOutput("reinit_x3", rd_data[XLEN-1:0], 32'h0);
    checkOutput("reinit_x4_busy", XLEN'(rd_busy), 32'h0);
    rd_addr = {5'd6, 5'd5};
    #1;
    checkOutput("reinit_x5", rd_data[XLEN-1:0], 32'h0);
    checkOutput("reinit_x6", rd_data[2*XLEN-1:XLEN], 32'h0);

    // Reset pulse at cnt==10 must restart a full 32-cycle walk.
    @(posedge clk);
    #1;
    init_req = 1'b1;
    @(posedge clk);
    #1;
    init_req = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_done_low", XLEN'(init_done), 32'h0);
    #1;
    rst_n = 1'b1;
    waitInit("midreset_cycles", 32);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
